// File: rtl/jstk2_spi_reader_pkg.sv
// Shared types and constants for the Pmod JSTK2 SPI reader.
// The byte indices give the order in which the JSTK2 returns its fields.
package jstk2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam int NUM_BYTES     = 5;
  localparam int BITS_PER_BYTE = 8;

  localparam logic [9:0] CENTRE_VAL = 10'd512;

  localparam logic [2:0] IDX_X_LO = 3'd0;
  localparam logic [2:0] IDX_X_HI = 3'd1;
  localparam logic [2:0] IDX_Y_LO = 3'd2;
  localparam logic [2:0] IDX_Y_HI = 3'd3;
  localparam logic [2:0] IDX_BTN  = 3'd4;

  // Only the two low bits of a high byte carry position data.
  function automatic logic [9:0] join10(input logic [1:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/jstk2_spi_reader_if.sv
// SPI bus between the reader (master) and the JSTK2 (slave).
interface jstk2_spi_reader_if;
  logic sclk;
  logic mosi;
  logic ss_n;
  logic miso;

  modport master (output sclk, output mosi, output ss_n, input miso);
  modport slave  (input sclk, input mosi, input ss_n, output miso);
endinterface

// File: rtl/jstk2_spi_reader_spi_byte_shift.sv
// One SPI mode-0 byte exchange: sclk low half then high half per bit,
// MISO captured on the rising edge, MOSI advanced on the falling edge.
module spi_byte_shift
  import jstk2_pkg::*;
#(
  parameter int SCLK_HALF = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_done,
  output logic [7:0] o_rx
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);

  logic          r_busy;
  logic          r_sclk;
  logic [HW-1:0] r_half;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          w_edge;

  assign w_edge = r_busy && (r_half == HALF_LAST);
  // Done coincides with the final falling edge so the caller can move on that cycle.
  assign o_done = w_edge && r_sclk && (r_bit == BIT_LAST);
  assign o_sclk = r_sclk;
  assign o_mosi = r_tx[7];
  assign o_rx   = r_rx;

  // Half-period timing, shift registers and busy flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_half <= {HW{1'b0}};
      r_bit  <= 3'd0;
      r_tx   <= 8'h00;
      r_rx   <= 8'h00;
    end else if (!r_busy) begin
      r_sclk <= 1'b0;
      r_half <= {HW{1'b0}};
      r_bit  <= 3'd0;
      r_tx   <= i_tx;
      r_busy <= i_start;
    end else if (w_edge) begin
      r_half <= {HW{1'b0}};
      r_sclk <= ~r_sclk;
      if (!r_sclk) begin
        r_rx <= {r_rx[6:0], i_miso};
      end else begin
        r_tx   <= {r_tx[6:0], 1'b0};
        r_bit  <= r_bit + 3'd1;
        r_busy <= (r_bit != BIT_LAST);
      end
    end else begin
      r_half <= r_half + HW'(1);
    end
  end

endmodule

// File: rtl/jstk2_spi_reader.sv
// Periodic JSTK2 poller: frames five SPI bytes, shadows them and publishes
// X/Y/buttons atomically with a one-cycle data_valid pulse.
module jstk2_spi_reader
  import jstk2_pkg::*;
#(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         SCLK_HALF   = 100,
  parameter int         SS_SETUP    = 1500,
  parameter int         INTER_BYTE  = 1000,
  parameter int         SS_HOLD     = 2500,
  parameter int         POLL_CYCLES = 1_000_000,
  parameter logic [7:0] CMD         = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  jstk2_spi_reader_if.master  spi,
  output logic [9:0]          x_val,
  output logic [9:0]          y_val,
  output logic [1:0]          btn,
  output logic                data_valid
);

  localparam int PH_A   = (SS_SETUP > INTER_BYTE) ? SS_SETUP : INTER_BYTE;
  localparam int PH_MAX = (PH_A > SS_HOLD) ? PH_A : SS_HOLD;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int PLW    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [PW-1:0]  SETUP_LAST = PW'(SS_SETUP - 1);
  localparam logic [PW-1:0]  GAP_LAST   = PW'(INTER_BYTE - 1);
  localparam logic [PW-1:0]  HOLD_LAST  = PW'(SS_HOLD - 1);
  localparam logic [PLW-1:0] POLL_LAST  = PLW'(POLL_CYCLES - 1);

  state_t         r_state;
  logic [PW-1:0]  r_phase;
  logic [PLW-1:0] r_poll;
  logic [2:0]     r_idx;
  logic           r_ss_n;
  logic [7:0]     r_x_lo;
  logic [1:0]     r_x_hi;
  logic [7:0]     r_y_lo;
  logic [1:0]     r_y_hi;
  logic [9:0]     r_x;
  logic [9:0]     r_y;
  logic [1:0]     r_btn;
  logic           r_valid;

  logic           w_start;
  logic [7:0]     w_tx;
  logic           w_sclk;
  logic           w_mosi;
  logic           w_byte_done;
  logic [7:0]     w_rx;

  assign w_start = ((r_state == SETUP) && (r_phase == SETUP_LAST)) ||
                   ((r_state == GAP)   && (r_phase == GAP_LAST));
  // Only the first byte carries the command; the shifter loads it as SETUP ends.
  assign w_tx    = (r_state == SETUP) ? CMD : 8'h00;

  spi_byte_shift #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_tx    (w_tx),
    .i_miso  (spi.miso),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi),
    .o_done  (w_byte_done),
    .o_rx    (w_rx)
  );

  assign spi.sclk   = w_sclk;
  assign spi.mosi   = w_mosi;
  assign spi.ss_n   = r_ss_n;
  assign x_val      = r_x;
  assign y_val      = r_y;
  assign btn        = r_btn;
  assign data_valid = r_valid;

  // Poll timer, transaction framing and atomic output update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_phase <= {PW{1'b0}};
      r_poll  <= {PLW{1'b0}};
      r_idx   <= 3'd0;
      r_ss_n  <= 1'b1;
      r_x_lo  <= 8'h00;
      r_x_hi  <= 2'b00;
      r_y_lo  <= 8'h00;
      r_y_hi  <= 2'b00;
      r_x     <= CENTRE_VAL;
      r_y     <= CENTRE_VAL;
      r_btn   <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      r_poll  <= (r_poll == POLL_LAST) ? {PLW{1'b0}} : r_poll + PLW'(1);
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ss_n <= 1'b1;
          if (r_poll == {PLW{1'b0}}) begin
            r_state <= SETUP;
            r_ss_n  <= 1'b0;
            r_phase <= {PW{1'b0}};
            r_idx   <= 3'd0;
          end
        end
        SETUP: begin
          if (r_phase == SETUP_LAST) begin
            r_state <= SHIFT;
            r_phase <= {PW{1'b0}};
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        SHIFT: begin
          if (w_byte_done) begin
            case (r_idx)
              IDX_X_LO: r_x_lo <= w_rx;
              IDX_X_HI: r_x_hi <= w_rx[1:0];
              IDX_Y_LO: r_y_lo <= w_rx;
              IDX_Y_HI: r_y_hi <= w_rx[1:0];
              default:  r_x_lo <= r_x_lo;
            endcase
            if (r_idx == IDX_BTN) begin
              r_state <= DONE;
              r_ss_n  <= 1'b1;
              r_x     <= join10(r_x_hi, r_x_lo);
              r_y     <= join10(r_y_hi, r_y_lo);
              r_btn   <= w_rx[1:0];
              r_valid <= 1'b1;
            end else begin
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (r_phase == GAP_LAST) begin
            r_state <= SHIFT;
            r_phase <= {PW{1'b0}};
            r_idx   <= r_idx + 3'd1;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        DONE: begin
          r_state <= HOLD;
          r_phase <= {PW{1'b0}};
        end
        HOLD: begin
          if (r_phase == HOLD_LAST) begin
            r_state <= IDLE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ss_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk2_spi_reader.sv
// Directed + randomized bench for jstk2_spi_reader with a behavioural JSTK2 slave.
`timescale 1ns/1ps
module tb_jstk2_spi_reader;

  localparam int         H     = 4;
  localparam int         SETUP = 10;
  localparam int         GAPC  = 6;
  localparam int         HOLDC = 20;
  localparam int         POLL  = 2000;
  localparam logic [7:0] CMD_B = 8'hA5;
  localparam int         TXN   = SETUP + 5 * 16 * H + 4 * GAPC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] x_val;
  logic [9:0] y_val;
  logic [1:0] btn;
  logic       data_valid;

  jstk2_spi_reader_if spi ();

  jstk2_spi_reader #(
    .CLK_HZ      (100_000_000),
    .SCLK_HALF   (H),
    .SS_SETUP    (SETUP),
    .INTER_BYTE  (GAPC),
    .SS_HOLD     (HOLDC),
    .POLL_CYCLES (POLL),
    .CMD         (CMD_B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi),
    .x_val      (x_val),
    .y_val      (y_val),
    .btn        (btn),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural JSTK2: presents resp[] MSB first, records MOSI at each sclk rise.
  logic [7:0] resp [5];
  logic [7:0] cap  [5];
  int   bitpos = 0;
  logic slv_ss_q = 1'b1;
  logic slv_sclk_q = 1'b0;

  always @(spi.ss_n or spi.sclk) begin
    if (slv_ss_q !== 1'b0 && spi.ss_n === 1'b0) begin
      bitpos = 0;
      for (int i = 0; i < 5; i++) cap[i] = 8'h00;
      spi.miso = resp[0][7];
    end else if (spi.ss_n === 1'b0) begin
      if (slv_sclk_q === 1'b0 && spi.sclk === 1'b1 && bitpos < 40) begin
        cap[bitpos / 8] = {cap[bitpos / 8][6:0], spi.mosi};
        bitpos++;
      end else if (slv_sclk_q === 1'b1 && spi.sclk === 1'b0 && bitpos > 0 && bitpos < 40) begin
        spi.miso = resp[bitpos / 8][7 - (bitpos % 8)];
      end
    end
    slv_ss_q   = spi.ss_n;
    slv_sclk_q = spi.sclk;
  end

  // Cycle-level monitor: timing of ss_n/sclk and output stability.
  int   cyc = 0;
  logic rst_edge = 1'b0;
  logic mon_ss_q = 1'b1;
  logic mon_sclk_q = 1'b0;
  int   ss_fall_cyc = -1;
  int   ss_rise_cyc = -1;
  int   first_rise_cyc = -1;
  int   last_fall_cyc = -1;
  int   rises = 0;
  int   gaps_long = 0;
  int   gaps_bad = 0;
  int   idle_sclk_viol = 0;
  int   out_viol = 0;
  int   dv_cycs [$];
  logic [21:0] prev_out = 22'h0;

  always begin
    @(posedge clk);
    cyc++;
    rst_edge = rst;
    @(negedge clk);
    if (mon_ss_q && !spi.ss_n) begin
      ss_fall_cyc = cyc; rises = 0; gaps_long = 0; gaps_bad = 0;
      first_rise_cyc = -1; last_fall_cyc = -1;
    end
    if (!mon_ss_q && spi.ss_n) ss_rise_cyc = cyc;
    if (!mon_sclk_q && spi.sclk) begin
      rises++;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
      else if (cyc - last_fall_cyc == GAPC + H) gaps_long++;
      else if (cyc - last_fall_cyc != H) gaps_bad++;
    end
    if (mon_sclk_q && !spi.sclk) last_fall_cyc = cyc;
    if (spi.ss_n === 1'b1 && spi.sclk !== 1'b0) idle_sclk_viol++;
    if (data_valid === 1'b1) dv_cycs.push_back(cyc);
    if (rst_edge && data_valid !== 1'b1 && {x_val, y_val, btn} !== prev_out) out_viol++;
    prev_out   = {x_val, y_val, btn};
    mon_ss_q   = spi.ss_n;
    mon_sclk_q = spi.sclk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_dv(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick(1);
      if (data_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_txn(input string tag);
    int ex, ey, eb;
    ex = int'(resp[0]) + 256 * (int'(resp[1]) % 4);
    ey = int'(resp[2]) + 256 * (int'(resp[3]) % 4);
    eb = int'(resp[4]) % 4;
    chk({tag, "_x"}, 32'(x_val), 32'(ex));
    chk({tag, "_y"}, 32'(y_val), 32'(ey));
    chk({tag, "_btn"}, 32'(btn), 32'(eb));
    chk({tag, "_rises"}, 32'(rises), 32'd40);
    chk({tag, "_sslen"}, 32'(ss_rise_cyc - ss_fall_cyc), 32'(TXN));
    chk({tag, "_mosi0"}, 32'(cap[0]), 32'(CMD_B));
    chk({tag, "_mosi_rest"}, 32'(cap[1] | cap[2] | cap[3] | cap[4]), 32'd0);
  endtask

  initial begin
    logic ok;
    int   rel;
    int   prev_dv;
    int   n_dv;
    for (int i = 0; i < 5; i++) resp[i] = 8'h00;
    spi.miso = 1'b0;

    rst = 1'b0;
    tick(4);
    chk("rst_ss_n", 32'(spi.ss_n), 32'd1);
    chk("rst_sclk", 32'(spi.sclk), 32'd0);
    chk("rst_mosi", 32'(spi.mosi), 32'd0);
    chk("rst_x", 32'(x_val), 32'd512);
    chk("rst_y", 32'(y_val), 32'd512);
    chk("rst_btn", 32'(btn), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);

    resp[0] = 8'h34; resp[1] = 8'h02; resp[2] = 8'hCD; resp[3] = 8'h01; resp[4] = 8'h03;
    rst = 1'b1;
    rel = cyc;
    wait_dv(TXN + 100, ok);
    chk("first_dv_seen", 32'(ok), 32'd1);
    chk("first_start", 32'(ss_fall_cyc), 32'(rel + 1));
    chk("first_x", 32'(x_val), 32'h234);
    chk("first_y", 32'(y_val), 32'h1CD);
    chk("first_btn", 32'(btn), 32'h3);
    chk("setup_to_rise", 32'(first_rise_cyc - ss_fall_cyc), 32'(SETUP + H));
    chk("byte_gaps", 32'(gaps_long), 32'd4);
    chk("bit_timing", 32'(gaps_bad), 32'd0);
    check_txn("t0");
    prev_dv = cyc;
    tick(1);
    chk("dv_width", 32'(data_valid), 32'd0);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 5; i++) resp[i] = 8'($urandom_range(0, 255));
      if (p == 1) begin
        resp[1] = 8'hFF; resp[3] = 8'hFC; resp[4] = 8'hFE;
      end
      wait_dv(POLL + 100, ok);
      chk("poll_dv_seen", 32'(ok), 32'd1);
      chk("poll_spacing", 32'(cyc - prev_dv), 32'(POLL));
      check_txn("poll");
      if (p == 1) begin
        chk("mask_xhi", 32'(x_val[9:8]), 32'd3);
        chk("mask_yhi", 32'(y_val[9:8]), 32'd0);
        chk("mask_btn", 32'(btn), 32'd2);
      end
      prev_dv = cyc;
    end

    for (int i = 0; i < 5; i++) resp[i] = 8'($urandom_range(0, 255));
    ok = 1'b0;
    for (int i = 0; i < POLL + 100 && !ok; i++) begin
      tick(1);
      if (spi.ss_n === 1'b0 && bitpos == 20) ok = 1'b1;
    end
    chk("reach_byte3", 32'(ok), 32'd1);
    n_dv = dv_cycs.size();
    rst = 1'b0;
    tick(1);
    chk("abort_ss_n", 32'(spi.ss_n), 32'd1);
    chk("abort_sclk", 32'(spi.sclk), 32'd0);
    chk("abort_x", 32'(x_val), 32'd512);
    chk("abort_y", 32'(y_val), 32'd512);
    chk("abort_btn", 32'(btn), 32'd0);
    chk("abort_dv", 32'(data_valid), 32'd0);
    rst = 1'b1;
    rel = cyc;
    wait_dv(TXN + 100, ok);
    chk("restart_dv_seen", 32'(ok), 32'd1);
    chk("restart_start", 32'(ss_fall_cyc), 32'(rel + 1));
    chk("restart_dv_count", 32'(dv_cycs.size()), 32'(n_dv + 1));
    check_txn("restart");

    tick(5);
    chk("sclk_idle_low", 32'(idle_sclk_viol), 32'd0);
    chk("outputs_held", 32'(out_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/jstk2_spi_reader.md
Name: jstk2_spi_reader

Overview:
- SPI master that periodically polls the Pmod JSTK2 and publishes 10-bit X/Y positions and button state.
- Sits directly upstream of the X/Y steering stages; its x_val output feeds the rear-wheel steering PWM block unchanged.
- Outputs update atomically once per completed 5-byte transaction and hold between transactions.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; documentation only, not used in arithmetic.
- SCLK_HALF, 100, clk cycles per SCLK half-period (default gives 500 kHz SCLK); must be >= 2.
- SS_SETUP, 1500, clk cycles from ss_n low to first SCLK edge (15 us).
- INTER_BYTE, 1000, idle clk cycles between bytes with ss_n held low (10 us).
- SS_HOLD, 2500, clk cycles ss_n stays high after a transaction before the next poll may start (25 us).
- POLL_CYCLES, 1_000_000, clk cycles between transaction starts (10 ms); must exceed total transaction length.
- CMD, 8'h00, first MOSI byte; bytes 2-5 on MOSI are 8'h00.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- miso  in  1  JSTK2 MISO, already synchronised externally
- sclk  out  1  SPI clock, mode 0 (idle low)
- mosi  out  1  SPI data out, MSB first
- ss_n  out  1  slave select, active-low
- x_val  out  10  latest X position, 0..1023
- y_val  out  10  latest Y position, 0..1023
- btn  out  2  bit0 = joystick button, bit1 = trigger
- data_valid  out  1  one-cycle pulse when x_val, y_val and btn have just updated

Behaviour:
- Reset (rst == 0 at a clk edge) has effect on that edge:
  - ss_n = 1, sclk = 0, mosi = 0.
  - x_val = y_val = 10'd512 (centre, so downstream steering stays neutral), btn = 0, data_valid = 0.
  - Poll timer = 0, FSM = IDLE.
- Reset asserted mid-transaction:
  - Aborts immediately; ss_n is high on the following cycle.
  - Partially received bytes are discarded.
  - Outputs take their reset values, not the last received data.
- Poll timer is free-running modulo POLL_CYCLES. It is 0 on the first cycle after reset, so the first transaction starts on the first cycle out of reset, then every POLL_CYCLES cycles thereafter.
- FSM states:
  - IDLE: ss_n = 1. Moves to SETUP when the poll timer reaches 0.
  - SETUP: ss_n = 0 and mosi = MSB of the current byte. After SS_SETUP cycles, moves to SHIFT with byte index = 0.
  - SHIFT: 8 bits, each lasting 2*SCLK_HALF cycles.
    - sclk low for the first half, high for the second.
    - MISO is sampled on the cycle sclk rises.
    - mosi changes on the cycle sclk falls, or on entry for bit 7.
    - After bit 0 completes with sclk back low: if byte index < 4, moves to GAP; otherwise moves to DONE.
  - GAP: ss_n = 0, sclk = 0. After INTER_BYTE cycles, increments byte index and returns to SHIFT.
  - DONE: ss_n goes high on entry. On the entry cycle, the assembled values are registered to the outputs and data_valid pulses for exactly 1 cycle. Moves to HOLD.
  - HOLD: ss_n = 1 for SS_HOLD cycles, then moves to IDLE.
- Byte mapping (received order):
  - b0 = X[7:0], b1[1:0] = X[9:8], b2 = Y[7:0], b3[1:0] = Y[9:8], b4[1:0] = btn.
  - b1[7:2], b3[7:2] and b4[7:2] are ignored.
- Received bytes go to a shadow register. Outputs never show a mix of old and new bytes.
- A poll tick arriving during a transaction or HOLD is not queued. The next transaction starts at the next tick after reaching IDLE.
- Counters are sized with $clog2 of their parameter, without overflow.
- Total transaction length = SS_SETUP + 5*16*SCLK_HALF + 4*INTER_BYTE.

Decomposition:
- Package jstk2_pkg:
  - FSM state enum (IDLE, SETUP, SHIFT, GAP, DONE, HOLD).
  - Byte count constant 5 and bit-per-byte constant 8.
  - CENTRE_VAL = 10'd512.
  - Byte-index localparams for X_LO, X_HI, Y_LO, Y_HI, BTN.
- One sub-module is natural: spi_byte_shift. It handles a single mode-0 byte exchange with start/done handshake, SCLK_HALF timing, and shift-in/shift-out registers. The top level owns polling, inter-byte gaps, framing and output latching.

Test Plan:
- Reset release with a behavioural JSTK2 slave returning {8'h34, 8'h02, 8'hCD, 8'h01, 8'h03}:
  - After the first transaction: x_val = 10'h234, y_val = 10'h1CD, btn = 2'b11.
  - data_valid pulses high for 1 cycle.
- Timing check with SCLK_HALF = 4, SS_SETUP = 10, INTER_BYTE = 6:
  - ss_n-low to first sclk rise = 10 + 4 cycles.
  - 40 sclk rises per transaction, 6-cycle low gaps between bytes, sclk low whenever ss_n is high.
- MOSI check with CMD = 8'hA5: the slave captures 8'hA5 then four 8'h00 bytes, MSB first, stable at every sclk rise.
- Upper-bit masking: slave returns b1 = 8'hFF, b3 = 8'hFC, b4 = 8'hFE. Requires x_val[9:8] = 2'b11, y_val[9:8] = 2'b00, btn = 2'b10.
- Reset pulsed during byte 3 of a transaction:
  - ss_n high next cycle; x_val = y_val = 512, btn = 0; no data_valid.
  - A clean transaction starts on the first cycle after release.
- POLL_CYCLES = 2000 over 5 polls: data_valid pulses are exactly 2000 cycles apart, and outputs are constant between pulses.
